// File: rtl/alu_result_serializer_if.sv
// Result-capture and byte-stream handshake bundle for alu_result_serializer.
// slave  : the serializer side (accepts results, produces bytes).
// master : the upstream ALU / downstream consumer side.
interface alu_result_serializer_if;
    logic        res_valid;
    logic [31:0] res_data;
    logic [3:0]  res_flags;
    logic        res_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_idx;
    logic        out_last;

    modport slave (
        input  res_valid, res_data, res_flags, out_ready,
        output res_ready, out_valid, out_data, out_idx, out_last
    );

    modport master (
        output res_valid, res_data, res_flags, out_ready,
        input  res_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/alu_result_serializer.sv
// alu_result_serializer: captures 32-bit ALU results plus flags into a small
// FIFO and streams each entry out as a byte frame over valid/ready.
// Frame: data[7:0], data[15:8], data[23:16], data[31:24], {4'b0, flags}.
// Optional macro RSER_CHECKSUM_EN appends a sixth byte, the XOR of the first
// five, computed combinationally from the head entry.
module alu_result_serializer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   clr_ovf,
    alu_result_serializer_if.slave bus,
    output logic [CW-1:0]          count,
    output logic                   ovf
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
`ifdef RSER_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd5;
`else
    localparam logic [2:0] LAST_IDX = 3'd4;
`endif

    logic [31:0]   data_mem [DEPTH];
    logic [3:0]    flag_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [2:0]    byte_idx;
    logic [31:0]   head_data;
    logic [3:0]    head_flags;
    logic [7:0]    out_byte;
    logic          push;
    logic          xfer;
    logic          xfer_last;

    // Ready/valid come straight from the registered occupancy, so a pop can
    // never make room for a push in the same cycle.
    assign bus.res_ready = (count != FULL);
    assign bus.out_valid = (count != '0);
    assign push          = bus.res_valid && bus.res_ready;
    assign xfer          = bus.out_valid && bus.out_ready;
    assign xfer_last     = xfer && (byte_idx == LAST_IDX);
    assign head_data     = data_mem[rd_ptr];
    assign head_flags    = flag_mem[rd_ptr];
    assign bus.out_data  = out_byte;
    assign bus.out_idx   = byte_idx;
    assign bus.out_last  = (byte_idx == LAST_IDX);

`ifdef RSER_CHECKSUM_EN
    logic [7:0] checksum;
    assign checksum = head_data[7:0] ^ head_data[15:8] ^ head_data[23:16]
                    ^ head_data[31:24] ^ {4'b0000, head_flags};
`endif

    // Select the current byte of the head entry.
    always_comb begin
        out_byte = 8'h00;
        case (byte_idx)
            3'd0:    out_byte = head_data[7:0];
            3'd1:    out_byte = head_data[15:8];
            3'd2:    out_byte = head_data[23:16];
            3'd3:    out_byte = head_data[31:24];
            3'd4:    out_byte = {4'b0000, head_flags};
`ifdef RSER_CHECKSUM_EN
            3'd5:    out_byte = checksum;
`endif
            default: out_byte = 8'h00;
        endcase
    end

    // Result storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            data_mem[wr_ptr] <= bus.res_data;
            flag_mem[wr_ptr] <= bus.res_flags;
        end
    end

    // Pointers, byte index and occupancy; flush abandons any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            byte_idx <= '0;
            count    <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            byte_idx <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (xfer_last) begin
                byte_idx <= '0;
                rd_ptr   <= rd_ptr + 1'b1;
            end else if (xfer) begin
                byte_idx <= byte_idx + 3'd1;
            end
            if (push && !xfer_last) begin
                count <= count + 1'b1;
            end else if (!push && xfer_last) begin
                count <= count - 1'b1;
            end
        end
    end

    // Sticky overflow: a result offered while full; setting beats clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (bus.res_valid && !bus.res_ready) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_result_serializer.sv
// Scoreboard bench for alu_result_serializer: each accepted result pushes its
// expected byte frame into a queue; each observed byte is compared to the head.
module tb_alu_result_serializer;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
`ifdef RSER_CHECKSUM_EN
    localparam int FR = 6;
`else
    localparam int FR = 5;
`endif

    typedef struct {
        logic [7:0] d;
        logic [2:0] i;
        logic       l;
    } byte_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          clr_ovf;
    logic [CW-1:0] count;
    logic          ovf;

    alu_result_serializer_if bus ();

    alu_result_serializer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .clr_ovf (clr_ovf),
        .bus     (bus),
        .count   (count),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    int    n_chk  = 0;
    int    n_pass = 0;
    byte_t sb_q[$];
    int    m_cnt  = 0;
    logic  m_ovf  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_frame(input logic [31:0] d, input logic [3:0] f);
        logic [7:0] b [6];
        logic [7:0] x;
        b[0] = d[7:0];
        b[1] = d[15:8];
        b[2] = d[23:16];
        b[3] = d[31:24];
        b[4] = {4'b0000, f};
        x = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
        b[5] = x;
        for (int k = 0; k < FR; k++) begin
            byte_t e;
            e.d = b[k];
            e.i = 3'(k);
            e.l = (k == FR - 1);
            sb_q.push_back(e);
        end
    endtask

    // Monitor: compare outputs against the model, then advance the model to
    // what the coming rising edge should do.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            logic m_ready;
            logic pop_last;
            logic do_push;
            m_ready = (m_cnt != DEPTH);
            check_eq("count", 32'(count), 32'(m_cnt));
            check_eq("count_bound", 32'(count <= CW'(DEPTH)), 32'd1);
            check_eq("res_ready", 32'(bus.res_ready), 32'(m_ready));
            check_eq("ovf", 32'(ovf), 32'(m_ovf));
            check_eq("out_valid", 32'(bus.out_valid), 32'(sb_q.size() != 0));
            pop_last = 1'b0;
            if (bus.out_valid && sb_q.size() != 0) begin
                check_eq("out_data", 32'(bus.out_data), 32'(sb_q[0].d));
                check_eq("out_idx", 32'(bus.out_idx), 32'(sb_q[0].i));
                check_eq("out_last", 32'(bus.out_last), 32'(sb_q[0].l));
            end
            do_push = bus.res_valid && m_ready;
            if (bus.res_valid && !m_ready) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            if (flush) begin
                sb_q.delete();
                m_cnt = 0;
            end else begin
                if (bus.out_valid && bus.out_ready && sb_q.size() != 0) begin
                    pop_last = sb_q[0].l;
                    void'(sb_q.pop_front());
                end
                if (do_push) push_frame(bus.res_data, bus.res_flags);
                m_cnt = m_cnt + (do_push ? 1 : 0) - (pop_last ? 1 : 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] d, input logic [3:0] f);
        bus.res_valid = 1'b1;
        bus.res_data  = d;
        bus.res_flags = f;
        tick();
        bus.res_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        clr_ovf = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data = '0;
        bus.res_flags = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_res_ready", 32'(bus.res_ready), 32'd1);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        tick();

        // 1: single frame streamed with consumer always ready
        bus.out_ready = 1'b1;
        push_one(32'h12345678, 4'b0010);
        check_eq("t1_count_after_push", 32'(count), 32'd1);
        check_eq("t1_first_byte", 32'(bus.out_data), 32'h78);
        repeat (FR) tick();
        check_eq("t1_count_drained", 32'(count), 32'd0);

        // 2: fill to full, overflow attempt, drain, clear ovf
        bus.out_ready = 1'b0;
        for (int k = 1; k <= DEPTH; k++) push_one(32'hA0000000 | 32'(k), 4'(k));
        push_one(32'hDEADBEEF, 4'hF);
        check_eq("t2_res_ready", 32'(bus.res_ready), 32'd0);
        check_eq("t2_count", 32'(count), 32'd4);
        check_eq("t2_ovf", 32'(ovf), 32'd1);
        bus.out_ready = 1'b1;
        repeat (FR * DEPTH) tick();
        check_eq("t2_drained", 32'(count), 32'd0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_eq("t2_ovf_cleared", 32'(ovf), 32'd0);

        // 3: full, final byte of head popped while a push is offered
        bus.out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) push_one(32'hB0B0B000 | 32'(k), 4'(k + 4));
        bus.out_ready = 1'b1;
        repeat (FR - 1) tick();
        check_eq("t3_at_last", 32'(bus.out_last), 32'd1);
        bus.res_valid = 1'b1;
        bus.res_data  = 32'hC0FFEE01;
        bus.res_flags = 4'b1001;
        tick();
        check_eq("t3_count_pop_no_push", 32'(count), 32'd3);
        tick();
        bus.res_valid = 1'b0;
        check_eq("t3_count_push", 32'(count), 32'd4);
        repeat (FR * DEPTH) tick();
        check_eq("t3_drained", 32'(count), 32'd0);

        // 4: push coinciding with the final byte of the only entry
        bus.out_ready = 1'b0;
        push_one(32'h11223344, 4'b0100);
        bus.out_ready = 1'b1;
        repeat (FR - 1) tick();
        push_one(32'h55667788, 4'b1000);
        check_eq("t4_count_same", 32'(count), 32'd1);
        check_eq("t4_new_idx0", 32'(bus.out_idx), 32'd0);
        check_eq("t4_new_byte0", 32'(bus.out_data), 32'h88);
        repeat (FR) tick();

        // 5: stalls during a frame
        bus.out_ready = 1'b0;
        push_one(32'h9ABCDEF0, 4'b0111);
        for (int k = 0; k < 4 * FR; k++) begin
            bus.out_ready = (k % 4 == 0) || (k % 4 == 3);
            tick();
        end
        bus.out_ready = 1'b1;
        repeat (FR) tick();
        check_eq("t5_drained", 32'(count), 32'd0);

        // 6: flush mid-frame keeps ovf; reset mid-frame drops out_valid at once
        bus.out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) push_one(32'hE0E0E0E0 + 32'(k), 4'(k));
        push_one(32'h0BADF00D, 4'h3);
        bus.out_ready = 1'b1;
        repeat (2) tick();
        check_eq("t6_idx2", 32'(bus.out_idx), 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("t6_flush_valid", 32'(bus.out_valid), 32'd0);
        check_eq("t6_flush_count", 32'(count), 32'd0);
        check_eq("t6_flush_ovf", 32'(ovf), 32'd1);
        push_one(32'hCAFEBABE, 4'b0001);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check_eq("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("t6_rst_ready", 32'(bus.res_ready), 32'd1);
        check_eq("t6_rst_ovf", 32'(ovf), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // recovery after reset
        push_one(32'h0F0E0D0C, 4'b1111);
        repeat (FR + 1) tick();
        check_eq("end_queue_empty", 32'(sb_q.size()), 32'd0);
        check_eq("end_count", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
